// File: rtl/arm_fetch_if.sv
// Fetch-stage bus bundle: instruction memory handshake, decode handoff,
// and pipeline control (redirect/halt) grouped for arm_fetch.
// master: the fetch unit; slave: memory/decode/execute side.
interface arm_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        halted;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output inst_valid, inst, inst_pc,
        input  inst_ready,
        input  redirect_valid, redirect_pc, halt,
        output halted
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  inst_valid, inst, inst_pc,
        output inst_ready,
        output redirect_valid, redirect_pc, halt,
        input  halted
    );
endinterface

// File: rtl/arm_fetch.sv
// arm_fetch: instruction fetch stage. Owns the PC, issues one outstanding
// word read at a time, buffers returned words with their PC in a small FIFO
// for decode, supports branch redirect and stops permanently on halt.
// Optional macro ARM_FETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt.
module arm_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    arm_fetch_if.master bus
`ifdef ARM_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {RUN, HALTED} state_t;

    state_t             state;
    logic [31:0]        pc;
    logic [31:0]        req_pc;
    logic               outstanding;
    logic               drop;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [31:0]        fifo_inst [FIFO_DEPTH];
    logic [31:0]        fifo_pc   [FIFO_DEPTH];

    logic run;
    logic req;
    logic hs;
    logic rsp;
    logic flush;
    logic push;
    logic pop;
    logic head_valid;

    // Request/response qualification; req is held low while rst is asserted.
    always_comb begin
        run        = (state == RUN);
        head_valid = (count != '0);
        req        = run & ~rst & ~bus.halt & ~bus.redirect_valid & ~outstanding
                     & (count < CNT_W'(FIFO_DEPTH));
        hs         = req & bus.imem_gnt;
        rsp        = bus.imem_rvalid & outstanding;
        flush      = run & (bus.halt | bus.redirect_valid);
        push       = rsp & ~drop & run & ~flush;
        pop        = head_valid & bus.inst_ready & ~flush;
    end

    // Control FSM: PC, outstanding/drop tracking, FIFO pointers and state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            req_pc      <= '0;
            outstanding <= 1'b0;
            drop        <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            if (hs)
                outstanding <= 1'b1;
            else if (bus.imem_rvalid)
                outstanding <= 1'b0;

            case (state)
                RUN: begin
                    if (bus.halt) begin
                        state  <= HALTED;
                        rd_ptr <= '0;
                        wr_ptr <= '0;
                        count  <= '0;
                    end else if (bus.redirect_valid) begin
                        // A response landing in the redirect cycle is discarded
                        // here, so only a still-pending one needs dropping later.
                        pc     <= bus.redirect_pc & ~32'h3;
                        drop   <= outstanding & ~bus.imem_rvalid;
                        rd_ptr <= '0;
                        wr_ptr <= '0;
                        count  <= '0;
                    end else begin
                        if (hs) begin
                            pc     <= pc + 32'd4;
                            req_pc <= pc;
                        end
                        if (rsp && drop)
                            drop <= 1'b0;
                        if (push)
                            wr_ptr <= wr_ptr + 1'b1;
                        if (pop)
                            rd_ptr <= rd_ptr + 1'b1;
                        count <= count + CNT_W'(push) - CNT_W'(pop);
                    end
                end
                default: ;
            endcase
        end
    end

    // FIFO storage: returned word and the PC it was fetched from.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_inst[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (push) begin
            fifo_inst[wr_ptr] <= bus.imem_rdata;
            fifo_pc[wr_ptr]   <= req_pc;
        end
    end

    // Output drive from registered state.
    always_comb begin
        bus.imem_req   = req;
        bus.imem_addr  = pc;
        bus.inst_valid = head_valid;
        bus.inst       = head_valid ? fifo_inst[rd_ptr] : '0;
        bus.inst_pc    = head_valid ? fifo_pc[rd_ptr]   : '0;
        bus.halted     = (state == HALTED);
    end

`ifdef ARM_FETCH_PERF_EN
    // Performance counters; both conditions imply RUN so they freeze in HALTED.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (push)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (req && !bus.imem_gnt)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_arm_fetch.sv
// Directed self-checking bench for arm_fetch: cycle vector table for
// streaming/backpressure/redirect, hand sequences for halt and reset.
module tb_arm_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    arm_fetch_if bus();

`ifdef ARM_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    arm_fetch #(.RESET_PC(32'h0040_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ARM_FETCH_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] mw(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic add(input logic g, input logic rv, input logic [31:0] ra,
                       input logic rdy, input logic rd, input logic [31:0] rp,
                       input logic er, input logic [31:0] ea,
                       input logic eiv, input logic [31:0] ep);
        vec_t v;
        v.gnt = g; v.rvalid = rv; v.rdata = mw(ra); v.ready = rdy;
        v.redir = rd; v.rpc = rp; v.e_req = er; v.e_addr = ea;
        v.e_iv = eiv; v.e_pc = ep;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                         input logic rdy, input logic rdr, input logic [31:0] rp,
                         input logic h);
        bus.imem_gnt       = g;
        bus.imem_rvalid    = rv;
        bus.imem_rdata     = rd;
        bus.inst_ready     = rdy;
        bus.redirect_valid = rdr;
        bus.redirect_pc    = rp;
        bus.halt           = h;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req"},     {31'd0, bus.imem_req},   32'd0);
        chk({tag, " ivalid"},  {31'd0, bus.inst_valid}, 32'd0);
        chk({tag, " inst"},    bus.inst,                32'd0);
        chk({tag, " inst_pc"}, bus.inst_pc,             32'd0);
        chk({tag, " halted"},  {31'd0, bus.halted},     32'd0);
`ifdef ARM_FETCH_PERF_EN
        chk({tag, " perf_fetch"}, perf_fetch_cnt, 32'd0);
        chk({tag, " perf_stall"}, perf_stall_cnt, 32'd0);
`endif
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);

        // streaming with 1-cycle rvalid, backpressure, stall, push+pop, stray rvalid
        add(1,0,0,0,0,0,                   1,32'h0040_0000, 0,0);
        add(0,1,32'h0040_0000,0,0,0,       0,0,             0,0);
        add(1,0,0,1,0,0,                   1,32'h0040_0004, 1,32'h0040_0000);
        add(0,1,32'h0040_0004,0,0,0,       0,0,             0,0);
        add(1,0,0,0,0,0,                   1,32'h0040_0008, 1,32'h0040_0004);
        add(0,1,32'h0040_0008,0,0,0,       0,0,             1,32'h0040_0004);
        add(0,0,0,0,0,0,                   0,0,             1,32'h0040_0004);
        add(0,0,0,0,0,0,                   0,0,             1,32'h0040_0004);
        add(0,0,0,1,0,0,                   0,0,             1,32'h0040_0004);
        add(0,0,0,0,0,0,                   1,32'h0040_000C, 1,32'h0040_0008);
        add(1,0,0,1,0,0,                   1,32'h0040_000C, 1,32'h0040_0008);
        add(0,1,32'h0040_000C,1,0,0,       0,0,             0,0);
        add(1,0,0,0,0,0,                   1,32'h0040_0010, 1,32'h0040_000C);
        add(0,1,32'h0040_0010,1,0,0,       0,0,             1,32'h0040_000C);
        add(0,0,0,1,0,0,                   1,32'h0040_0014, 1,32'h0040_0010);
        add(0,1,32'h0000_BAD0,0,0,0,       1,32'h0040_0014, 0,0);
        add(0,0,0,0,0,0,                   1,32'h0040_0014, 0,0);
        // redirect with request outstanding: stale response dropped
        add(1,0,0,0,0,0,                   1,32'h0040_0014, 0,0);
        add(0,0,0,0,1,32'h0040_0101,       0,0,             0,0);
        add(0,1,32'h0040_0014,0,0,0,       0,0,             0,0);
        add(1,0,0,0,0,0,                   1,32'h0040_0100, 0,0);
        add(0,1,32'h0040_0100,0,0,0,       0,0,             0,0);
        add(0,0,0,1,0,0,                   1,32'h0040_0104, 1,32'h0040_0100);
        // redirect coinciding with rvalid: that word never surfaces
        add(1,0,0,0,0,0,                   1,32'h0040_0104, 0,0);
        add(0,1,32'h0040_0104,0,1,32'h0040_0200, 0,0,       0,0);
        add(1,0,0,0,0,0,                   1,32'h0040_0200, 0,0);
        add(0,1,32'h0040_0200,0,0,0,       0,0,             0,0);
        add(0,0,0,0,0,0,                   1,32'h0040_0204, 1,32'h0040_0200);
        // redirect flushes a non-empty FIFO
        add(0,0,0,0,1,32'h0040_0300,       0,0,             1,32'h0040_0200);
        add(0,0,0,0,0,0,                   1,32'h0040_0300, 0,0);

        @(negedge clk);
        @(negedge clk);
        #1;
        chk_reset_outputs("reset");

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            if (i == 0) rst = 1'b0;
            drive(vq[i].gnt, vq[i].rvalid, vq[i].rdata, vq[i].ready,
                  vq[i].redir, vq[i].rpc, 1'b0);
            #1;
            chk($sformatf("v%0d req", i), {31'd0, bus.imem_req}, {31'd0, vq[i].e_req});
            if (vq[i].e_req)
                chk($sformatf("v%0d addr", i), bus.imem_addr, vq[i].e_addr);
            chk($sformatf("v%0d ivalid", i), {31'd0, bus.inst_valid}, {31'd0, vq[i].e_iv});
            if (vq[i].e_iv) begin
                chk($sformatf("v%0d inst_pc", i), bus.inst_pc, vq[i].e_pc);
                chk($sformatf("v%0d inst", i), bus.inst, mw(vq[i].e_pc));
            end
            chk($sformatf("v%0d halted", i), {31'd0, bus.halted}, 32'd0);
        end

        // halt together with redirect while a request is outstanding
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("h1 req", {31'd0, bus.imem_req}, 32'd1);
        chk("h1 addr", bus.imem_addr, 32'h0040_0300);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 32'h0040_0500, 1);
        #1;
        chk("h2 req", {31'd0, bus.imem_req}, 32'd0);
        chk("h2 halted", {31'd0, bus.halted}, 32'd0);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            drive(1, (n == 0 || n == 5), mw(32'h0040_0300), 1,
                  (n % 3 == 0), 32'h0040_0500, 0);
            #1;
            chk($sformatf("hl%0d halted", n), {31'd0, bus.halted}, 32'd1);
            chk($sformatf("hl%0d req", n), {31'd0, bus.imem_req}, 32'd0);
            chk($sformatf("hl%0d ivalid", n), {31'd0, bus.inst_valid}, 32'd0);
        end
        chk("halted pc frozen", bus.imem_addr, 32'h0040_0304);
`ifdef ARM_FETCH_PERF_EN
        chk("halted perf_fetch", perf_fetch_cnt, 32'd7);
        chk("halted perf_stall", perf_stall_cnt, 32'd7);
`endif

        // leave HALTED via reset, then reset again mid-stream
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst1");
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("r0 req", {31'd0, bus.imem_req}, 32'd1);
        chk("r0 addr", bus.imem_addr, 32'h0040_0000);
        @(negedge clk);
        drive(0, 1, mw(32'h0040_0000), 0, 0, 0, 0);
        #1;
        chk("r1 req", {31'd0, bus.imem_req}, 32'd0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("r2 ivalid", {31'd0, bus.inst_valid}, 32'd1);
        chk("r2 inst_pc", bus.inst_pc, 32'h0040_0000);
        chk("r2 addr", bus.imem_addr, 32'h0040_0004);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst2");
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1, 32'h1234_5678, 0, 0, 0, 0);
        #1;
        chk("r4 req", {31'd0, bus.imem_req}, 32'd1);
        chk("r4 addr", bus.imem_addr, 32'h0040_0000);
        chk("r4 ivalid", {31'd0, bus.inst_valid}, 32'd0);
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0);
            #1;
            chk($sformatf("r5_%0d req", n), {31'd0, bus.imem_req}, 32'd1);
            chk($sformatf("r5_%0d addr", n), bus.imem_addr, 32'h0040_0000);
        end
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("r7 addr", bus.imem_addr, 32'h0040_0000);
        chk("r7 ivalid", {31'd0, bus.inst_valid}, 32'd0);
`ifdef ARM_FETCH_PERF_EN
        chk("r7 perf_stall", perf_stall_cnt, 32'd3);
`endif
        @(negedge clk);
        drive(0, 1, mw(32'h0040_0000), 0, 0, 0, 0);
        #1;
        chk("r8 req", {31'd0, bus.imem_req}, 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("r9 ivalid", {31'd0, bus.inst_valid}, 32'd1);
        chk("r9 inst_pc", bus.inst_pc, 32'h0040_0000);
        chk("r9 inst", bus.inst, mw(32'h0040_0000));
`ifdef ARM_FETCH_PERF_EN
        chk("r9 perf_fetch", perf_fetch_cnt, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
